fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address.
- Pairs each 24-bit word the ROM returns with the address it was fetched from, and presents the pair to decode as a valid-qualified fetch slot.
- Supports decode back-pressure (stall) and branch redirect with flush, compensating for the ROM's one-cycle registered read.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the registered-read ROM and pairs
// each returned word with its fetch address, with stall skid and branch flush.
module fetch_unit #(
    parameter int          ADDR_W   = 16,
    parameter int          INST_W   = 24,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
    logic              req_valid_reg, req_valid_next;
    logic              hold_reg, hold_next;
    logic [INST_W-1:0] hold_inst_reg, hold_inst_next;
    logic [INST_W-1:0] inst_sel;

    always_comb begin
        pc_next        = pc_reg;
        req_pc_next    = req_pc_reg;
        req_valid_next = req_valid_reg;
        hold_next      = hold_reg;
        hold_inst_next = hold_inst_reg;
        if (branch_taken) begin
            // The word arriving next cycle belongs to the old path: drop it.
            pc_next        = branch_target;
            req_valid_next = 1'b0;
            hold_next      = 1'b0;
        end else if (stall) begin
            // The ROM re-reads pc_reg during a stall, so capture the slot's word once.
            if (!hold_reg) begin
                hold_next      = 1'b1;
                hold_inst_next = rom_data;
            end
        end else begin
            req_pc_next    = pc_reg;
            req_valid_next = 1'b1;
            pc_next        = pc_reg + ADDR_W'(PC_STEP);
            hold_next      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= ADDR_W'(RESET_PC);
            req_pc_reg    <= '0;
            req_valid_reg <= 1'b0;
            hold_reg      <= 1'b0;
            hold_inst_reg <= '0;
        end else begin
            pc_reg        <= pc_next;
            req_pc_reg    <= req_pc_next;
            req_valid_reg <= req_valid_next;
            hold_reg      <= hold_next;
            hold_inst_reg <= hold_inst_next;
        end
    end

    assign rom_addr = pc_reg;
    assign if_valid = req_valid_reg;
    assign if_pc    = req_pc_reg;
    assign inst_sel = hold_reg ? hold_inst_reg : rom_data;

    genvar gi;
    generate
        for (gi = 0; gi < INST_W; gi++) begin : g_inst_gate
            assign if_inst[gi] = inst_sel[gi] & req_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural registered-read ROM.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [23:0] if_inst;

    logic [23:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(16), .INST_W(24), .RESET_PC(0), .PC_STEP(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .rom_addr(rom_addr), .rom_data(rom_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b stall=%0b br=%0b tgt=%h | rom_addr=%h v=%0b pc=%h inst=%h",
                 $time, rst, stall, branch_taken, branch_target, rom_addr, if_valid, if_pc, if_inst);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b0, 16'h0, 24'h0}) begin
            errors++;
            $display("FAIL reset_slot: got v=%0b pc=%h inst=%h, expected v=0 pc=0000 inst=000000",
                     if_valid, if_pc, if_inst);
        end
        checks++;
        if (rom_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h, expected 0000", rom_addr);
        end
    endtask

    task automatic test_sequence();
        logic [23:0] exp_inst [0:5];
        exp_inst[0] = 24'h000001; exp_inst[1] = 24'hFAA000; exp_inst[2] = 24'h000003;
        exp_inst[3] = 24'h000004; exp_inst[4] = 24'h000005; exp_inst[5] = 24'hF66060;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_inst} !== {1'b1, 16'(i), exp_inst[i]}) begin
                errors++;
                $display("FAIL seq_slot%0d: got v=%0b pc=%h inst=%h, expected v=1 pc=%h inst=%h",
                         i, if_valid, if_pc, if_inst, 16'(i), exp_inst[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rst = 1'b0;
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_inst, rom_addr} !== {1'b1, 16'h0001, 24'hFAA000, 16'h0002}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%0b pc=%h inst=%h rom_addr=%h, expected v=1 pc=0001 inst=faa000 rom_addr=0002",
                         i, if_valid, if_pc, if_inst, rom_addr);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0002, 24'h000003}) begin
            errors++;
            $display("FAIL stall_release: got v=%0b pc=%h inst=%h, expected v=1 pc=0002 inst=000003",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_redirect();
        branch_taken = 1'b1; branch_target = 16'h0005;
        step();
        branch_taken = 1'b0;
        checks++;
        if ({if_valid, if_inst} !== {1'b0, 24'h0}) begin
            errors++;
            $display("FAIL redirect_bubble: got v=%0b inst=%h, expected v=0 inst=000000", if_valid, if_inst);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0005, 24'hF66060}) begin
            errors++;
            $display("FAIL redirect_target: got v=%0b pc=%h inst=%h, expected v=1 pc=0005 inst=f66060",
                     if_valid, if_pc, if_inst);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0006, 24'h000007}) begin
            errors++;
            $display("FAIL redirect_next: got v=%0b pc=%h inst=%h, expected v=1 pc=0006 inst=000007",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0001;
        step();
        stall = 1'b0; branch_taken = 1'b0;
        checks++;
        if ({if_valid, if_inst, rom_addr} !== {1'b0, 24'h0, 16'h0001}) begin
            errors++;
            $display("FAIL brstall_bubble: got v=%0b inst=%h rom_addr=%h, expected v=0 inst=000000 rom_addr=0001",
                     if_valid, if_inst, rom_addr);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0001, 24'hFAA000}) begin
            errors++;
            $display("FAIL brstall_target: got v=%0b pc=%h inst=%h, expected v=1 pc=0001 inst=faa000",
                     if_valid, if_pc, if_inst);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0002, 24'h000003}) begin
            errors++;
            $display("FAIL brstall_next: got v=%0b pc=%h inst=%h, expected v=1 pc=0002 inst=000003",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [0:2];
        logic [15:0] exp_addr [0:2];
        logic [23:0] exp_inst [0:2];
        exp_pc[0] = 16'hFFFE;   exp_pc[1] = 16'hFFFF;   exp_pc[2] = 16'h0000;
        exp_addr[0] = 16'hFFFF; exp_addr[1] = 16'h0000; exp_addr[2] = 16'h0001;
        exp_inst[0] = 24'hC0FFFE; exp_inst[1] = 24'hC0FFFF; exp_inst[2] = 24'h000001;
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        checks++;
        if ({if_valid, rom_addr} !== {1'b0, 16'hFFFE}) begin
            errors++;
            $display("FAIL wrap_bubble: got v=%0b rom_addr=%h, expected v=0 rom_addr=fffe", if_valid, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({if_valid, if_pc, if_inst, rom_addr} !== {1'b1, exp_pc[i], exp_inst[i], exp_addr[i]}) begin
                errors++;
                $display("FAIL wrap_slot%0d: got v=%0b pc=%h inst=%h rom_addr=%h, expected v=1 pc=%h inst=%h rom_addr=%h",
                         i, if_valid, if_pc, if_inst, rom_addr, exp_pc[i], exp_inst[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_double_redirect();
        branch_taken = 1'b1; branch_target = 16'h0004;
        step();
        branch_target = 16'h0003;
        step();
        branch_taken = 1'b0;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL dblbr_bubble: got v=%0b, expected v=0", if_valid);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0003, 24'h000004}) begin
            errors++;
            $display("FAIL dblbr_target: got v=%0b pc=%h inst=%h, expected v=1 pc=0003 inst=000004",
                     if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_reset_stall();
        stall = 1'b1;
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0003, 24'h000004}) begin
            errors++;
            $display("FAIL rststall_hold: got v=%0b pc=%h inst=%h, expected v=1 pc=0003 inst=000004",
                     if_valid, if_pc, if_inst);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({if_valid, if_inst, rom_addr} !== {1'b0, 24'h0, 16'h0000}) begin
            errors++;
            $display("FAIL rststall_reset: got v=%0b inst=%h rom_addr=%h, expected v=0 inst=000000 rom_addr=0000",
                     if_valid, if_inst, rom_addr);
        end
        rst = 1'b0; stall = 1'b0;
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0000, 24'h000001}) begin
            errors++;
            $display("FAIL rststall_restart0: got v=%0b pc=%h inst=%h, expected v=1 pc=0000 inst=000001",
                     if_valid, if_pc, if_inst);
        end
        step();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 16'h0001, 24'hFAA000}) begin
            errors++;
            $display("FAIL rststall_restart1: got v=%0b pc=%h inst=%h, expected v=1 pc=0001 inst=faa000",
                     if_valid, if_pc, if_inst);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = {8'hC0, 16'(i)};
        mem[0] = 24'h000001; mem[1] = 24'hFAA000; mem[2] = 24'h000003;
        mem[3] = 24'h000004; mem[4] = 24'h000005; mem[5] = 24'hF66060;
        mem[6] = 24'h000007;
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;

        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_branch_stall();
        test_wrap();
        test_double_redirect();
        test_reset_stall();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
